// File: rtl/mem_bus_ctrl_if.sv
// Request/response handshake plus memory control lines for mem_bus_ctrl.
// master = requester/memory side, slave = controller side.
interface mem_bus_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_addr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_addr
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-word controller for a 16x16 shared-bus memory; owns bus direction and turnaround.
// Optional write-verify readback enabled by MEM_BUS_CTRL_VERIFY_EN.
module mem_bus_ctrl #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_bus_ctrl_if.slave   bif,
    inout  wire  [DW-1:0]   mem_bus,
    output logic            verr
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_TURN, S_RD, S_RCAP} state_t;

    state_t        r_state, w_next;
    logic          r_mem_en, w_mem_en;
    logic          r_oe, w_oe;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_wdata, w_wdata;
    logic          r_rsp_valid, w_rsp_valid;
    logic [DW-1:0] r_rdata, w_rdata;
`ifdef MEM_BUS_CTRL_VERIFY_EN
    logic          r_vfy, w_vfy;
    logic          r_verr, w_verr;
`endif

    always_comb begin
        w_next      = r_state;
        w_mem_en    = r_mem_en;
        w_oe        = r_oe;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_rsp_valid = 1'b0;
        w_rdata     = r_rdata;
`ifdef MEM_BUS_CTRL_VERIFY_EN
        w_vfy       = r_vfy;
        w_verr      = r_verr;
`endif
        case (r_state)
            S_IDLE: begin
                if (bif.req_valid) begin
                    w_addr = bif.req_addr;
                    if (bif.req_we) begin
                        w_next   = S_WR;
                        w_mem_en = 1'b1;
                        w_oe     = 1'b1;
                        w_wdata  = bif.req_wdata;
                    end else if (r_mem_en) begin
                        // memory still in capture mode: give it one cycle to start driving
                        w_next   = S_TURN;
                        w_mem_en = 1'b0;
                        w_oe     = 1'b0;
                    end else begin
                        w_next   = S_RD;
                    end
                end
            end
            S_WR: begin
                w_oe = 1'b0;
`ifdef MEM_BUS_CTRL_VERIFY_EN
                w_next   = S_TURN;
                w_mem_en = 1'b0;
                w_vfy    = 1'b1;
`else
                w_next   = S_IDLE;
`endif
            end
            S_TURN: w_next = S_RD;
            S_RD:   w_next = S_RCAP;
            S_RCAP: begin
                w_next = S_IDLE;
`ifdef MEM_BUS_CTRL_VERIFY_EN
                if (r_vfy) begin
                    w_vfy = 1'b0;
                    if (mem_bus != r_wdata) w_verr = 1'b1;
                end else begin
                    w_rsp_valid = 1'b1;
                    w_rdata     = mem_bus;
                end
`else
                w_rsp_valid = 1'b1;
                w_rdata     = mem_bus;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_en    <= 1'b0;
            r_oe        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_next;
            r_mem_en    <= w_mem_en;
            r_oe        <= w_oe;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_rsp_valid <= w_rsp_valid;
            r_rdata     <= w_rdata;
        end
    end

`ifdef MEM_BUS_CTRL_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vfy  <= 1'b0;
            r_verr <= 1'b0;
        end else begin
            r_vfy  <= w_vfy;
            r_verr <= w_verr;
        end
    end
    assign verr = r_verr;
`else
    assign verr = 1'b0;
`endif

    // Driving while the memory also drives would short the bus.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(r_oe && !r_mem_en));
    end

    assign mem_bus       = r_oe ? r_wdata : 'z;
    assign bif.req_ready = (r_state == S_IDLE);
    assign bif.rsp_valid = r_rsp_valid;
    assign bif.rsp_rdata = r_rdata;
    assign bif.mem_en    = r_mem_en;
    assign bif.mem_addr  = r_addr;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
`ifdef MEM_BUS_CTRL_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int WR_READY = VFY ? 5 : 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire  [15:0] mem_bus;
  logic        verr;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  mem_bus_ctrl_if #(.AW(4), .DW(16)) bif ();
  mem_bus_ctrl #(.AW(4), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bif(bif.slave), .mem_bus(mem_bus), .verr(verr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    fails++;
    $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [15:0] mem [16];
  logic [15:0] rd_q = '0;
  always @(posedge clk) begin
    rd_q <= mem[bif.mem_addr] | ((bif.mem_addr == 4'd7) ? 16'h0001 : 16'h0000);
    if (bif.mem_en && dut.r_oe) mem[bif.mem_addr] <= mem_bus;
  end
  assign mem_bus = (!bif.mem_en) ? rd_q : 'z;

  typedef struct { logic [15:0] d; int lat; int acc; } exp_t;
  exp_t        sq[$];
  logic [15:0] shadow [16];
  bit          en_hi = 1'b0;

  always @(negedge clk) begin
    if (rst_n && bif.rsp_valid) begin
      if (sq.size() == 0) begin
        tests++;
        fail("rsp_unexpected", bif.rsp_valid, 1'b0);
      end else begin
        exp_t e;
        e = sq.pop_front();
        tests++;
        if (bif.rsp_rdata !== e.d) fail("rsp_data", bif.rsp_rdata, e.d);
        tests++;
        if ((cyc - e.acc + 1) !== e.lat) fail("rsp_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic handshake(input bit we, input logic [3:0] a, input logic [15:0] d,
                           output int waited);
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_addr = a; bif.req_wdata = d;
    waited = 0;
    while (!bif.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      tests++;
      fail("handshake_timeout", bif.req_ready, 1'b1);
    end
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, output int waited);
    int n;
    handshake(1'b1, a, d, waited);
    tests++;
    if (bif.mem_en !== 1'b1) fail("wr_en", bif.mem_en, 1'b1);
    tests++;
    if (bif.mem_addr !== a) fail("wr_addr", bif.mem_addr, a);
    tests++;
    if (mem_bus !== d) fail("wr_bus", mem_bus, d);
    tests++;
    if (bif.req_ready !== 1'b0) fail("wr_busy", bif.req_ready, 1'b0);
    n = 1;
    while (!bif.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n !== WR_READY) fail("wr_ready_lat", n, WR_READY);
    tests++;
    if (bif.mem_en !== !VFY) fail("wr_en_after", bif.mem_en, !VFY);
    shadow[a] = d;
    en_hi = !VFY;
  endtask

  task automatic do_read(input logic [3:0] a);
    int   w;
    exp_t e;
    handshake(1'b0, a, 16'h0, w);
    tests++;
    if (bif.mem_en !== 1'b0) fail("rd_en", bif.mem_en, 1'b0);
    tests++;
    if (bif.mem_addr !== a) fail("rd_addr", bif.mem_addr, a);
    e.d = shadow[a] | ((a == 4'd7) ? 16'h0001 : 16'h0000);
    e.lat = en_hi ? 4 : 3;
    e.acc = cyc;
    sq.push_back(e);
    en_hi = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sq.size() !== 0) fail("drain", sq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    for (int unsigned i = 0; i < 16; i++) begin mem[i] = '0; shadow[i] = '0; end
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;

    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      bif.req_valid = 1'($urandom); bif.req_we = 1'($urandom);
      bif.req_addr = 4'($urandom); bif.req_wdata = 16'($urandom);
      tests++;
      if (bif.mem_en !== 1'b0) fail("rst_mem_en", bif.mem_en, 1'b0);
      tests++;
      if (dut.r_oe !== 1'b0) fail("rst_oe", dut.r_oe, 1'b0);
      tests++;
      if (bif.rsp_valid !== 1'b0) fail("rst_rsp_valid", bif.rsp_valid, 1'b0);
    end
    tests++;
    if (bif.mem_addr !== 4'h0) fail("rst_mem_addr", bif.mem_addr, 4'h0);
    tests++;
    if (bif.rsp_rdata !== 16'h0) fail("rst_rdata", bif.rsp_rdata, 16'h0);
    tests++;
    if (verr !== 1'b0) fail("rst_verr", verr, 1'b0);
    bif.req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    tests++;
    if (bif.req_ready !== 1'b1) fail("ready_after_rst", bif.req_ready, 1'b1);

    do_write(4'd3, 16'hA5A5, w);
    tests++;
    if (w !== 0) fail("first_accept_wait", w, 0);
    do_read(4'd3);
    drain();

    for (int unsigned i = 0; i < 16; i++) do_write(4'(i), 16'(i * 16'h1111), w);
    for (int unsigned i = 0; i < 16; i++) do_read(4'(i));
    drain();
    do_read(4'd15);
    do_read(4'd0);
    drain();

    do_write(4'd7, 16'h0000, w);
    tests++;
    if (verr !== VFY) fail("verr_set", verr, VFY);
    do_write(4'd7, 16'h1235, w);
    do_write(4'd2, 16'h4444, w);
    tests++;
    if (verr !== VFY) fail("verr_sticky", verr, VFY);
    do_read(4'd2);
    drain();

    handshake(1'b1, 4'd9, 16'hBEEF, w);
    tests++;
    if (dut.r_oe !== 1'b1) fail("wr_drive_before_rst", dut.r_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (dut.r_oe !== 1'b0) fail("rst_wr_oe", dut.r_oe, 1'b0);
    tests++;
    if (bif.mem_en !== 1'b0) fail("rst_wr_en", bif.mem_en, 1'b0);
    tests++;
    if (verr !== 1'b0) fail("rst_wr_verr", verr, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    en_hi = 1'b0;

    handshake(1'b0, 4'd3, 16'h0, w);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (dut.r_oe !== 1'b0) fail("rst_rcap_oe", dut.r_oe, 1'b0);
    tests++;
    if (bif.req_ready !== 1'b1) fail("rst_rcap_ready", bif.req_ready, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bif.rsp_valid !== 1'b0) fail("rst_rcap_no_rsp", bif.rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bif.rsp_valid !== 1'b0) fail("post_rst_no_rsp", bif.rsp_valid, 1'b0);
    end

    do_read(4'd5);
    drain();
    do_write(4'd0, 16'h5A5A, w);
    do_read(4'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
